// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, the FSM
// state type, and helpers for access size and byte-strobe masks.
package mem_stage_pkg;

    // RISC-V load/store funct3 encodings (size in [1:0], unsigned in [2])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Map encodings that are illegal for this datapath width onto W.
    function automatic logic [2:0] norm_funct3(input logic [2:0] f3, input int xlen);
        logic [2:0] r;
        r = f3;
        if (f3 == 3'b111) r = F3_W;
        if (xlen < 64 && (f3 == F3_D || f3 == F3_WU)) r = F3_W;
        return r;
    endfunction

    // log2 of the access size in bytes; expects a normalised funct3.
    function automatic logic [1:0] size_log2(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 2'd0;
            F3_H, F3_HU: return 2'd1;
            F3_D:        return 2'd3;
            default:     return 2'd2;
        endcase
    endfunction

    // Byte-lane mask for an access of 2**sz bytes starting at lane 0.
    function automatic logic [7:0] strobe_mask(input logic [1:0] sz);
        return 8'((16'd1 << (4'd1 << sz)) - 16'd1);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the addressed bytes down to lane 0, truncates
// to the access size and sign- or zero-extends to the full datapath width.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              read_data,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [2:0]                   funct3,
    output logic [XLEN-1:0]              load_data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] fill;
    logic [1:0]      sz;
    logic            sign_bit;

    // Shift, mask to size, then fill the upper bits with the extension value.
    always_comb begin
        // NOTE: every signal written here gets a value first, so no path leaves one unassigned and no latch is inferred.
        shifted   = read_data >> {offset, 3'b000};
        sz        = size_log2(funct3);
        keep      = (XLEN'(1) << (7'd8 << sz)) - XLEN'(1);
        sign_bit  = shifted[XLEN-1];
        case (sz)
            2'd0:    sign_bit = shifted[7];
            2'd1:    sign_bit = shifted[15];
            2'd2:    sign_bit = shifted[31];
            default: sign_bit = shifted[XLEN-1];
        endcase
        fill      = (sign_bit && !funct3[2]) ? '1 : '0;
        load_data = (shifted & keep) | (fill & ~keep);
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: accepts one access per ALU_kick_up, drives data memory
// with byte strobes under a ready handshake, and returns aligned load data
// with a one-cycle MEM_kick_up completion pulse.
// Build option: MEM_MISALIGN_TRAP_EN -- when defined, misaligned accesses are
// flagged and skipped; otherwise the address is force-aligned to the size.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ALU_result,
    input  logic                  ALU_kick_up,
    input  logic [XLEN-1:0]       reg_read_data_2,
    input  logic                  Controller_memwrite,
    input  logic                  Controller_memread,
    input  logic [2:0]            Controller_funct3,
    output logic                  Data_mem_write_enable,
    output logic [ADDR_WIDTH-1:0] Data_mem_write_addr,
    output logic [XLEN-1:0]       Data_mem_write_data,
    output logic [XLEN/8-1:0]     Data_mem_write_strobe,
    output logic                  Data_mem_read_enable,
    output logic [ADDR_WIDTH-1:0] Data_mem_read_addr,
    input  logic [XLEN-1:0]       Data_mem_read_data,
    input  logic                  Data_mem_ready,
    output logic [XLEN-1:0]       MEM_load_data,
    output logic                  MEM_kick_up,
    output logic                  MEM_busy,
    output logic                  MEM_misaligned,
    output logic                  MEM_bus_error
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       data_q;
    logic [2:0]            funct3_q;
    logic                  is_store_q;
    logic                  is_load_q;
    logic [CNT_W-1:0]      wait_cnt_q;
    logic [XLEN-1:0]       load_data_q;
    logic                  bus_error_q;

    logic [2:0]            kick_funct3;
    logic                  kick_mem;
    logic                  kick_misaligned;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [OFF_W-1:0]      eff_off;
    logic                  timeout_hit;
    logic                  access_live;
    logic [XLEN-1:0]       aligned_load;

    assign kick_funct3 = norm_funct3(Controller_funct3, XLEN);
    assign kick_mem    = Controller_memwrite | Controller_memread;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign kick_misaligned = |(ALU_result[OFF_W-1:0] &
                               OFF_W'((1 << size_log2(kick_funct3)) - 1));
    assign eff_addr        = addr_q;
    assign MEM_misaligned  = misaligned_q;

    // Misaligned flag: captured from the incoming access, cleared on each accepted kick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misaligned_q <= 1'b0;
        else if (state_q == ST_IDLE && ALU_kick_up)
            misaligned_q <= kick_misaligned;
    end
`else
    logic [OFF_W-1:0] low_mask;

    assign kick_misaligned = 1'b0;
    assign low_mask        = OFF_W'((1 << size_log2(funct3_q)) - 1);
    assign eff_addr        = {addr_q[ADDR_WIDTH-1:OFF_W], addr_q[OFF_W-1:0] & ~low_mask};
    assign MEM_misaligned  = 1'b0;
`endif

    assign eff_off     = eff_addr[OFF_W-1:0];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign access_live = (state_q == ST_ACCESS) && !timeout_hit;

    // Memory port: decoded from state so a reset drops the enables at once.
    assign Data_mem_write_enable = access_live && is_store_q;
    assign Data_mem_read_enable  = access_live && is_load_q;
    assign Data_mem_write_addr   = eff_addr;
    assign Data_mem_read_addr    = eff_addr;
    assign Data_mem_write_data   = data_q << {eff_off, 3'b000};
    assign Data_mem_write_strobe = Data_mem_write_enable
                                 ? (STRB_W'(strobe_mask(size_log2(funct3_q))) << eff_off)
                                 : '0;

    assign MEM_kick_up   = (state_q == ST_DONE);
    assign MEM_busy      = (state_q != ST_IDLE);
    assign MEM_load_data = load_data_q;
    assign MEM_bus_error = bus_error_q;

    mem_load_align #(.XLEN(XLEN)) u_load_align (
        .read_data (Data_mem_read_data),
        .offset    (eff_off),
        .funct3    (funct3_q),
        .load_data (aligned_load)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: kicks only land in IDLE, ready only matters in ACCESS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ALU_kick_up)
                    state_d = (!kick_mem || kick_misaligned) ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (timeout_hit || Data_mem_ready)
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request latch, wait counter, load capture and bus-error flag.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the data latches are reset too, so every output reads 0 straight out of reset.
        if (reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            funct3_q    <= '0;
            is_store_q  <= 1'b0;
            is_load_q   <= 1'b0;
            wait_cnt_q  <= '0;
            load_data_q <= '0;
            bus_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (ALU_kick_up) begin
                        addr_q      <= ALU_result;
                        data_q      <= reg_read_data_2;
                        funct3_q    <= kick_funct3;
                        is_store_q  <= Controller_memwrite;
                        is_load_q   <= Controller_memread && !Controller_memwrite;
                        wait_cnt_q  <= '0;
                        bus_error_q <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (timeout_hit)
                        bus_error_q <= 1'b1;
                    else if (Data_mem_ready) begin
                        if (is_load_q)
                            load_data_q <= aligned_load;
                    end else if (TIMEOUT_CYCLES != 0)
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32, TIMEOUT_CYCLES=16). Expected
// completions are queued when an access is issued and checked when
// MEM_kick_up appears; port-level values are checked in the first ACCESS cycle.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ALU_result = '0;
    logic        ALU_kick_up = 1'b0;
    logic [31:0] reg_read_data_2 = '0;
    logic        Controller_memwrite = 1'b0;
    logic        Controller_memread = 1'b0;
    logic [2:0]  Controller_funct3 = '0;
    logic        Data_mem_write_enable;
    logic [31:0] Data_mem_write_addr;
    logic [31:0] Data_mem_write_data;
    logic [3:0]  Data_mem_write_strobe;
    logic        Data_mem_read_enable;
    logic [31:0] Data_mem_read_addr;
    logic [31:0] Data_mem_read_data = '0;
    logic        Data_mem_ready = 1'b0;
    logic [31:0] MEM_load_data;
    logic        MEM_kick_up;
    logic        MEM_busy;
    logic        MEM_misaligned;
    logic        MEM_bus_error;

    mem_stage_lsu #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ALU_result            (ALU_result),
        .ALU_kick_up           (ALU_kick_up),
        .reg_read_data_2       (reg_read_data_2),
        .Controller_memwrite   (Controller_memwrite),
        .Controller_memread    (Controller_memread),
        .Controller_funct3     (Controller_funct3),
        .Data_mem_write_enable (Data_mem_write_enable),
        .Data_mem_write_addr   (Data_mem_write_addr),
        .Data_mem_write_data   (Data_mem_write_data),
        .Data_mem_write_strobe (Data_mem_write_strobe),
        .Data_mem_read_enable  (Data_mem_read_enable),
        .Data_mem_read_addr    (Data_mem_read_addr),
        .Data_mem_read_data    (Data_mem_read_data),
        .Data_mem_ready        (Data_mem_ready),
        .MEM_load_data         (MEM_load_data),
        .MEM_kick_up           (MEM_kick_up),
        .MEM_busy              (MEM_busy),
        .MEM_misaligned        (MEM_misaligned),
        .MEM_bus_error         (MEM_bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        int          kick_cyc;
        logic [31:0] load;
        logic        berr;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   vectors = 0;
    int   miscompares = 0;
    int   kicks_seen = 0;
    int   kicks_expected = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: ready after ready_delay wait cycles, junk data until then.
    int          ready_delay = 0;
    bit          ready_never = 1'b0;
    int          acc_cycles = 0;
    logic [31:0] mem_word = '0;

    always @(posedge clk) begin
        #1;
        if (Data_mem_write_enable || Data_mem_read_enable) acc_cycles++;
        else acc_cycles = 0;
        Data_mem_ready = (Data_mem_write_enable || Data_mem_read_enable) &&
                         !ready_never && (acc_cycles > ready_delay);
        Data_mem_read_data = Data_mem_ready ? mem_word : 32'h5A5A_5A5A;
    end

    // Completion monitor: pops the scoreboard on each MEM_kick_up.
    always @(negedge clk) begin
        if (!reset && MEM_kick_up) begin
            kicks_seen++;
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check({got.tag, "_kick_cycle"}, 64'(cyc), 64'(got.kick_cyc));
                check({got.tag, "_load_data"}, MEM_load_data, got.load);
                check({got.tag, "_bus_error"}, MEM_bus_error, got.berr);
                check({got.tag, "_misaligned"}, MEM_misaligned, got.mis);
            end
        end
    end

    // Issue one access; returns in cycle N+1 (1 time unit after the edge).
    task automatic issue(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic we, input logic re, input logic [2:0] f3,
                         input int lat, input logic [31:0] exp_load,
                         input logic exp_berr, input logic exp_mis, output int n);
        exp_t e;
        @(posedge clk); #1;
        ALU_result          = addr;
        reg_read_data_2     = data;
        Controller_memwrite = we;
        Controller_memread  = re;
        Controller_funct3   = f3;
        ALU_kick_up         = 1'b1;
        n          = cyc;
        e.tag      = tag;
        e.kick_cyc = n + lat;
        e.load     = exp_load;
        e.berr     = exp_berr;
        e.mis      = exp_mis;
        sb.push_back(e);
        kicks_expected++;
        @(posedge clk); #1;
        ALU_kick_up         = 1'b0;
        Controller_memwrite = 1'b0;
        Controller_memread  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while ((MEM_busy || sb.size() != 0) && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        check({tag, "_drained"}, 64'(sb.size() == 0 && !MEM_busy), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we",     Data_mem_write_enable, 0);
        check("rst_re",     Data_mem_read_enable, 0);
        check("rst_strobe", Data_mem_write_strobe, 0);
        check("rst_wdata",  Data_mem_write_data, 0);
        check("rst_addr",   Data_mem_write_addr, 0);
        check("rst_kick",   MEM_kick_up, 0);
        check("rst_busy",   MEM_busy, 0);
        check("rst_load",   MEM_load_data, 0);
        check("rst_flags",  {MEM_misaligned, MEM_bus_error}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // SW, zero-wait memory
        issue("sw", 32'h100, 32'hDEAD_BEEF, 1, 0, 3'b010, 2, 32'h0, 0, 0, n);
        check("sw_we",     Data_mem_write_enable, 1);
        check("sw_re",     Data_mem_read_enable, 0);
        check("sw_strobe", Data_mem_write_strobe, 4'b1111);
        check("sw_wdata",  Data_mem_write_data, 32'hDEAD_BEEF);
        check("sw_addr",   Data_mem_write_addr, 32'h100);
        wait_idle("sw");

        // SB to the top byte lane
        issue("sb", 32'h103, 32'h0000_00A5, 1, 0, 3'b000, 2, 32'h0, 0, 0, n);
        check("sb_strobe", Data_mem_write_strobe, 4'b1000);
        check("sb_wdata",  Data_mem_write_data, 32'hA500_0000);
        check("sb_addr",   Data_mem_write_addr, 32'h103);
        wait_idle("sb");

        // LB / LBU / LH / LHU extension
        mem_word = 32'h0080_0000;
        issue("lb", 32'h102, 32'h0, 0, 1, 3'b000, 2, 32'hFFFF_FF80, 0, 0, n);
        check("lb_re",   Data_mem_read_enable, 1);
        check("lb_we",   Data_mem_write_enable, 0);
        check("lb_addr", Data_mem_read_addr, 32'h102);
        wait_idle("lb");
        issue("lbu", 32'h102, 32'h0, 0, 1, 3'b100, 2, 32'h0000_0080, 0, 0, n);
        wait_idle("lbu");
        mem_word = 32'h8001_0000;
        issue("lh", 32'h102, 32'h0, 0, 1, 3'b001, 2, 32'hFFFF_8001, 0, 0, n);
        wait_idle("lh");
        mem_word = 32'h1234_F00D;
        issue("lhu", 32'h100, 32'h0, 0, 1, 3'b101, 2, 32'h0000_F00D, 0, 0, n);
        wait_idle("lhu");

        // LW with three wait states
        ready_delay = 3;
        mem_word    = 32'h89AB_CDEF;
        issue("lw_wait", 32'h200, 32'h0, 0, 1, 3'b010, 5, 32'h89AB_CDEF, 0, 0, n);
        check("lw_wait_re", Data_mem_read_enable, 1);
        wait_idle("lw_wait");
        ready_delay = 0;

        // Non-memory op: one-cycle latency, load data held
        issue("nop", 32'h123, 32'h0, 0, 0, 3'b010, 1, 32'h89AB_CDEF, 0, 0, n);
        check("nop_busy", MEM_busy, 1);
        check("nop_en",   {Data_mem_write_enable, Data_mem_read_enable}, 2'b00);
        wait_idle("nop");

        // Timeout: ready never arrives
        ready_never = 1'b1;
        issue("tmo", 32'h300, 32'h0, 0, 1, 3'b010, 18, 32'h89AB_CDEF, 1, 0, n);
        repeat (15) @(posedge clk);
        #1;
        check("tmo_en_held", Data_mem_read_enable, 1);
        @(posedge clk); #1;
        check("tmo_en_dropped", Data_mem_read_enable, 0);
        check("tmo_busy", MEM_busy, 1);
        wait_idle("tmo");
        ready_never = 1'b0;

        // Next kick clears the bus error
        issue("clr", 32'h0, 32'h0, 0, 0, 3'b000, 1, 32'h89AB_CDEF, 0, 0, n);
        wait_idle("clr");

        // memread and memwrite together act as a store
        issue("both", 32'h600, 32'h1122_3344, 1, 1, 3'b010, 2, 32'h89AB_CDEF, 0, 0, n);
        check("both_we", Data_mem_write_enable, 1);
        check("both_re", Data_mem_read_enable, 0);
        wait_idle("both");

        // Misaligned accesses
        mem_word = 32'hCAFE_BABE;
`ifdef MEM_MISALIGN_TRAP_EN
        issue("mis_lw", 32'h102, 32'h0, 0, 1, 3'b010, 1, 32'h89AB_CDEF, 0, 1, n);
        check("mis_lw_en", {Data_mem_write_enable, Data_mem_read_enable}, 2'b00);
        wait_idle("mis_lw");
        issue("mis_sh", 32'h101, 32'h0000_BEEF, 1, 0, 3'b001, 1, 32'h89AB_CDEF, 0, 1, n);
        check("mis_sh_en", {Data_mem_write_enable, Data_mem_read_enable}, 2'b00);
        wait_idle("mis_sh");
`else
        issue("mis_lw", 32'h102, 32'h0, 0, 1, 3'b010, 2, 32'hCAFE_BABE, 0, 0, n);
        check("mis_lw_addr", Data_mem_read_addr, 32'h100);
        check("mis_lw_re",   Data_mem_read_enable, 1);
        wait_idle("mis_lw");
        issue("mis_sh", 32'h101, 32'h0000_BEEF, 1, 0, 3'b001, 2, 32'hCAFE_BABE, 0, 0, n);
        check("mis_sh_addr",   Data_mem_write_addr, 32'h100);
        check("mis_sh_strobe", Data_mem_write_strobe, 4'b0011);
        check("mis_sh_wdata",  Data_mem_write_data, 32'h0000_BEEF);
        wait_idle("mis_sh");
`endif

        // Second kick during ACCESS is ignored
        ready_delay = 3;
        mem_word    = 32'h0F0F_0F0F;
        issue("busy", 32'h400, 32'h0, 0, 1, 3'b010, 5, 32'h0F0F_0F0F, 0, 0, n);
        @(posedge clk); #1;
        ALU_result          = 32'h700;
        reg_read_data_2     = 32'hFFFF_FFFF;
        Controller_memwrite = 1'b1;
        Controller_funct3   = 3'b010;
        ALU_kick_up         = 1'b1;
        @(posedge clk); #1;
        ALU_kick_up         = 1'b0;
        Controller_memwrite = 1'b0;
        check("busy_no_store", Data_mem_write_enable, 0);
        wait_idle("busy");
        repeat (4) @(posedge clk);
        #1;
        check("busy_one_kick", 64'(kicks_seen), 64'(kicks_expected));
        check("busy_idle_we", Data_mem_write_enable, 0);
        ready_delay = 0;

        // Reset in ACCESS: enables drop at once, no completion
        ready_never = 1'b1;
        @(posedge clk); #1;
        ALU_result         = 32'h500;
        Controller_memread = 1'b1;
        Controller_funct3  = 3'b010;
        ALU_kick_up        = 1'b1;
        @(posedge clk); #1;
        ALU_kick_up        = 1'b0;
        Controller_memread = 1'b0;
        check("rstacc_re_before", Data_mem_read_enable, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rstacc_re_after", Data_mem_read_enable, 0);
        check("rstacc_busy",     MEM_busy, 0);
        check("rstacc_load",     MEM_load_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        ready_never = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rstacc_no_kick", 64'(kicks_seen), 64'(kicks_expected));

        // Recovery after reset
        mem_word = 32'h1357_9BDF;
        issue("post_rst", 32'h10, 32'h0, 0, 1, 3'b010, 2, 32'h1357_9BDF, 0, 0, n);
        wait_idle("post_rst");
        check("total_kicks", 64'(kicks_seen), 64'(kicks_expected));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory-access stage for the RISC-V core, the successor to the current single-cycle MEM stage. It sits between ALU/EX and writeback. It accepts one access per `ALU_kick_up`, issues it to data memory with byte strobes and a ready handshake, and aligns and sign- or zero-extends load data. Completion is signalled with a one-cycle `MEM_kick_up` pulse.

## Interface
Parameters:
- `XLEN`, default 32: datapath width, 32 or 64.
- `ADDR_WIDTH`, default 32: address width.
- `TIMEOUT_CYCLES`, default 16: maximum number of WAIT cycles before abort. 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ALU_result` in ADDR_WIDTH: effective address.
- `ALU_kick_up` in 1: one-cycle pulse marking a new instruction.
- `reg_read_data_2` in XLEN: store data.
- `Controller_memwrite` in 1: store.
- `Controller_memread` in 1: load.
- `Controller_funct3` in 3: access size and sign (RISC-V encoding).
- `Data_mem_write_enable` out 1.
- `Data_mem_write_addr` out ADDR_WIDTH.
- `Data_mem_write_data` out XLEN.
- `Data_mem_write_strobe` out XLEN/8.
- `Data_mem_read_enable` out 1.
- `Data_mem_read_addr` out ADDR_WIDTH.
- `Data_mem_read_data` in XLEN.
- `Data_mem_ready` in 1: memory accepts the write, or read data is valid this cycle.
- `MEM_load_data` out XLEN: extended load result; held until the next completion.
- `MEM_kick_up` out 1: completion pulse.
- `MEM_busy` out 1: stage is occupied.
- `MEM_misaligned` out 1: sticky per access; cleared on the next accepted kick.
- `MEM_bus_error` out 1: timeout flag; same lifetime as `MEM_misaligned`.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE, on `ALU_kick_up`:**
  - Latch address, store data, funct3, and the op.
  - Clear both error flags.
  - If neither memread nor memwrite is set, go to DONE.
  - Otherwise go to ACCESS.
- **Simultaneous `Controller_memwrite` and `Controller_memread`:** the access is treated as a store.
- **ACCESS:**
  - Drive the enable (write or read), both addresses, data and strobes, held stable until `Data_mem_ready` is sampled 1.
  - On ready: capture load data, go to DONE.
  - The WAIT counter increments each ACCESS cycle with ready=0. When the count reaches `TIMEOUT_CYCLES` (if nonzero): drop the enable, set `MEM_bus_error`, leave `MEM_load_data` unchanged, go to DONE.
- **DONE:** `MEM_kick_up`=1 for exactly one cycle, then IDLE.
- **`MEM_busy`:** 1 in ACCESS and DONE. `ALU_kick_up` while busy is ignored (no queueing).
- **Sizes (funct3):**
  - 000 B, 001 H, 010 W; 011 D (XLEN=64 only).
  - 100 BU, 101 HU; 110 WU (XLEN=64 only).
  - Encodings that are illegal for XLEN are treated as W.
- **Offset:** `off` = address[log2(XLEN/8)-1:0].
- **Stores:**
  - Strobe = size mask << `off`.
  - Write data = store data << (8·`off`).
  - Address passed through unmodified.
- **Loads:** (read data >> 8·`off`) truncated to the size, then sign-extended (000/001/010) or zero-extended (1xx) to XLEN.
- **Misalignment:** `off` not a multiple of the size in bytes.

## Timing
- **Reset values:** every output 0; FSM in IDLE; counter 0; `MEM_load_data` 0.
- **Reset mid-access:** enables drop asynchronously and the transaction is abandoned. No `MEM_kick_up` is issued.
- **Non-memory op:** kick at cycle N gives `MEM_kick_up` at N+1.
- **Memory op:**
  - Enable asserted from N+1.
  - Ready at cycle N+k (k≥1) gives `MEM_kick_up` at N+k+1.
  - Zero-wait memory gives a 2-cycle latency.
- **Flags:** `MEM_load_data` and the error flags are valid from the `MEM_kick_up` cycle onward.
- **Ready outside ACCESS:** ignored.

## Configuration
- **`MEM_MISALIGN_TRAP_EN` defined:** a misaligned access sets `MEM_misaligned`, issues no memory enable, and goes straight to DONE (latency 1, load data unchanged).
- **Not defined:** the address is force-aligned to the access size (low bits cleared on the memory port and in the offset). `MEM_misaligned` is tied 0.

## Structure
- Shared package `mem_stage_pkg`:
  - funct3 size/sign localparams.
  - FSM state enum.
  - Strobe-mask function.
- One sub-module, `mem_load_align`: combinational shift plus extend, from read data, offset and funct3.
- The FSM, counter and store alignment stay in the top.

## Test plan
- **SW, ready tied 1:** addr 0x100, data 0xDEADBEEF → enable at N+1, strobe 4'b1111, `MEM_kick_up` at N+2.
- **SB:** addr 0x103, data 0x000000A5 → write data 0xA5000000, strobe 4'b1000.
- **LB vs LBU:** addr 0x102, mem word 0x0080_0000 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **Wait states and timeout:**
  - ready held 0 for 3 cycles → `MEM_kick_up` at N+5.
  - ready never asserted (TIMEOUT_CYCLES=16) → `MEM_bus_error`=1, kick at N+18.
- **Misalignment:** LW at 0x102 with macro defined → no enable, `MEM_misaligned`=1, kick at N+1. Without the macro, address 0x100 is issued.
- **Busy and reset:**
  - Second `ALU_kick_up` during ACCESS → ignored, exactly one `MEM_kick_up`.
  - Reset asserted in ACCESS → enables 0 immediately, no kick.
